// File: rtl/workflow_control_os_gen_pkg.sv
// Shared types and phase-length helpers for the output-stationary matmul sequencer.
package bisr_os_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        SHIFT_SEL,
        OUTPUT,
        DONE
    } os_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Last skewed element enters at t = K_DIM-1 + max(ROWS,COLS)-1.
    function automatic int feed_len(input int rows, input int cols, input int k_dim);
        return k_dim + max2(rows, cols) - 1;
    endfunction

    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/workflow_control_os_gen_if.sv
// Request/array-edge bundle between a matmul requester and the OS sequencer.
interface workflow_control_os_gen_if #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_DIM     = 4,
    parameter int WORD_SIZE = 16
);
    logic                            start;
    logic [ROWS*K_DIM*WORD_SIZE-1:0] left_matrix;
    logic [K_DIM*COLS*WORD_SIZE-1:0] top_matrix;
    logic [COLS*WORD_SIZE-1:0]       bottom_out;
    logic                            set_stationary;
    logic                            stat_bit_in;
    logic                            fsm_out_select_in;
    logic [ROWS*WORD_SIZE-1:0]       curr_cycle_left_in;
    logic [COLS*WORD_SIZE-1:0]       curr_cycle_top_in;
    logic [COLS*WORD_SIZE-1:0]       matmul_output;
    logic [COLS-1:0]                 output_col_valid;
    logic [$clog2(ROWS)-1:0]         result_row;
    logic                            busy;
    logic                            done;

    modport master (
        output start, left_matrix, top_matrix, bottom_out,
        input  set_stationary, stat_bit_in, fsm_out_select_in, curr_cycle_left_in,
               curr_cycle_top_in, matmul_output, output_col_valid, result_row, busy, done
    );

    modport slave (
        input  start, left_matrix, top_matrix, bottom_out,
        output set_stationary, stat_bit_in, fsm_out_select_in, curr_cycle_left_in,
               curr_cycle_top_in, matmul_output, output_col_valid, result_row, busy, done
    );
endinterface

// File: rtl/workflow_control_os_gen_skew_mux.sv
// Picks the diagonal (skewed) word per edge lane for feed step t; lane l carries k = t-l.
module os_skew_mux #(
    parameter int LANES       = 4,
    parameter int K_DIM       = 4,
    parameter int WORD_SIZE   = 16,
    parameter int LANE_STRIDE = 4,
    parameter int K_STRIDE    = 1,
    parameter int CW          = 4
) (
    input  logic [LANES*K_DIM*WORD_SIZE-1:0] matrix_i,
    input  logic [CW-1:0]                    t_i,
    output logic [LANES*WORD_SIZE-1:0]       bus_o
);
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WORD_SIZE-1:0] word;

        always_comb begin
            word = '0;
            for (int k = 0; k < K_DIM; k++) begin
                if (int'(t_i) == l + k)
                    word = matrix_i[(l*LANE_STRIDE + k*K_STRIDE)*WORD_SIZE +: WORD_SIZE];
            end
        end

        assign bus_o[l*WORD_SIZE +: WORD_SIZE] = word;
    end
endmodule

// File: rtl/workflow_control_os_gen.sv
// Output-stationary matmul sequencer: clears accumulators, feeds skewed A/B,
// drains the array, then shifts out and tags result rows bottom-first.
module workflow_control_os_gen
    import bisr_os_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int K_DIM     = 4,
    parameter int WORD_SIZE = 16
) (
    input logic clk,
    input logic rst,
    workflow_control_os_gen_if.slave bus
);
    localparam int FEED_LEN  = feed_len(ROWS, COLS, K_DIM);
    localparam int DRAIN_LEN = drain_len(ROWS, COLS);
    localparam int CNT_MAX   = max2(max2(FEED_LEN, DRAIN_LEN), ROWS);
    localparam int CW        = $clog2(CNT_MAX) + 1;
    localparam int RW        = $clog2(ROWS);

    os_state_e                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [ROWS*WORD_SIZE-1:0] left_q, left_d, left_w;
    logic [COLS*WORD_SIZE-1:0] top_q, top_d, top_w;

    os_skew_mux #(
        .LANES(ROWS), .K_DIM(K_DIM), .WORD_SIZE(WORD_SIZE),
        .LANE_STRIDE(K_DIM), .K_STRIDE(1), .CW(CW)
    ) u_left_skew (
        .matrix_i(bus.left_matrix), .t_i(cnt_q), .bus_o(left_w)
    );

    os_skew_mux #(
        .LANES(COLS), .K_DIM(K_DIM), .WORD_SIZE(WORD_SIZE),
        .LANE_STRIDE(1), .K_STRIDE(COLS), .CW(CW)
    ) u_top_skew (
        .matrix_i(bus.top_matrix), .t_i(cnt_q), .bus_o(top_w)
    );

    // One phase counter, cleared on every phase entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = FEED;
            end
            FEED: if (cnt_q == CW'(FEED_LEN - 1)) begin
                cnt_d   = '0;
                state_d = DRAIN;
            end
            DRAIN: if (cnt_q == CW'(DRAIN_LEN - 1)) begin
                cnt_d   = '0;
                state_d = SHIFT_SEL;
            end
            SHIFT_SEL: begin
                cnt_d   = '0;
                state_d = OUTPUT;
            end
            OUTPUT: if (cnt_q == CW'(ROWS - 1)) begin
                cnt_d   = '0;
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        left_d = (state_q == FEED) ? left_w : '0;
        top_d  = (state_q == FEED) ? top_w  : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            left_q  <= '0;
            top_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            top_q   <= top_d;
        end
    end

    assign bus.set_stationary     = 1'b0;
    assign bus.stat_bit_in        = (state_q == CLEAR);
    assign bus.fsm_out_select_in  = (state_q == SHIFT_SEL);
    assign bus.curr_cycle_left_in = left_q;
    assign bus.curr_cycle_top_in  = top_q;
    assign bus.matmul_output      = bus.bottom_out;
    assign bus.output_col_valid   = {COLS{state_q == OUTPUT}};
    // Shift-out presents the bottom row first.
    assign bus.result_row = (state_q == OUTPUT) ? RW'(ROWS - 1) - cnt_q[RW-1:0] : '0;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
endmodule

// File: tb/tb_workflow_control_os_gen.sv
// Scoreboard bench: four sequencer configurations share one behavioural OS array model.
module tb_workflow_control_os_gen;

    typedef struct {
        int          tag;
        logic [47:0] data;
        logic [2:0]  ocv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_v = 1'b0;
    int   sel = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    workflow_control_os_gen_if #(.ROWS(2), .COLS(2), .K_DIM(2), .WORD_SIZE(16)) if0 ();
    workflow_control_os_gen_if #(.ROWS(2), .COLS(3), .K_DIM(4), .WORD_SIZE(16)) if1 ();
    workflow_control_os_gen_if #(.ROWS(3), .COLS(3), .K_DIM(3), .WORD_SIZE(16)) if2 ();
    workflow_control_os_gen_if #(.ROWS(2), .COLS(2), .K_DIM(1), .WORD_SIZE(16)) if3 ();

    workflow_control_os_gen #(.ROWS(2), .COLS(2), .K_DIM(2), .WORD_SIZE(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
    workflow_control_os_gen #(.ROWS(2), .COLS(3), .K_DIM(4), .WORD_SIZE(16)) u1 (.clk(clk), .rst(rst), .bus(if1));
    workflow_control_os_gen #(.ROWS(3), .COLS(3), .K_DIM(3), .WORD_SIZE(16)) u2 (.clk(clk), .rst(rst), .bus(if2));
    workflow_control_os_gen #(.ROWS(2), .COLS(2), .K_DIM(1), .WORD_SIZE(16)) u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.start = start_v && (sel == 0);
    assign if1.start = start_v && (sel == 1);
    assign if2.start = start_v && (sel == 2);
    assign if3.start = start_v && (sel == 3);

    // Selected instance's outputs, zero-extended to the 3x3 maximum.
    logic [47:0] m_left, m_top, m_out;
    logic [2:0]  m_ocv;
    int          m_row, R, C;
    logic        m_stat, m_osel, m_busy, m_done, m_setst;

    always_comb begin
        m_left = '0; m_top = '0; m_out = '0; m_ocv = '0; m_row = 0;
        m_stat = 1'b0; m_osel = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_setst = 1'b0;
        R = 2; C = 2;
        case (sel)
            0: begin
                m_left = 48'(if0.curr_cycle_left_in); m_top = 48'(if0.curr_cycle_top_in);
                m_out = 48'(if0.matmul_output); m_ocv = 3'(if0.output_col_valid); m_row = int'(if0.result_row);
                m_stat = if0.stat_bit_in; m_osel = if0.fsm_out_select_in; m_busy = if0.busy;
                m_done = if0.done; m_setst = if0.set_stationary; R = 2; C = 2;
            end
            1: begin
                m_left = 48'(if1.curr_cycle_left_in); m_top = 48'(if1.curr_cycle_top_in);
                m_out = 48'(if1.matmul_output); m_ocv = 3'(if1.output_col_valid); m_row = int'(if1.result_row);
                m_stat = if1.stat_bit_in; m_osel = if1.fsm_out_select_in; m_busy = if1.busy;
                m_done = if1.done; m_setst = if1.set_stationary; R = 2; C = 3;
            end
            2: begin
                m_left = 48'(if2.curr_cycle_left_in); m_top = 48'(if2.curr_cycle_top_in);
                m_out = 48'(if2.matmul_output); m_ocv = 3'(if2.output_col_valid); m_row = int'(if2.result_row);
                m_stat = if2.stat_bit_in; m_osel = if2.fsm_out_select_in; m_busy = if2.busy;
                m_done = if2.done; m_setst = if2.set_stationary; R = 3; C = 3;
            end
            default: begin
                m_left = 48'(if3.curr_cycle_left_in); m_top = 48'(if3.curr_cycle_top_in);
                m_out = 48'(if3.matmul_output); m_ocv = 3'(if3.output_col_valid); m_row = int'(if3.result_row);
                m_stat = if3.stat_bit_in; m_osel = if3.fsm_out_select_in; m_busy = if3.busy;
                m_done = if3.done; m_setst = if3.set_stationary; R = 2; C = 2;
            end
        endcase
    end

    // Behavioural OS array: A flows right, B flows down, each PE accumulates a*b;
    // after the select pulse the accumulators shift down one row per clock.
    int acc [3][3], ar [3][3], br [3][3];
    int acc_n [3][3], ar_n [3][3], br_n [3][3], a_in [3][3], b_in [3][3];
    bit shm, shm_n;
    logic [47:0] bot48;

    always_comb begin
        acc_n = acc; ar_n = ar; br_n = br; shm_n = shm;
        a_in = '{default: 0}; b_in = '{default: 0};
        for (int r = 0; r < 3; r++) begin
            a_in[r][0] = int'(m_left[r*16 +: 16]);
            for (int c = 1; c < 3; c++) a_in[r][c] = ar[r][c-1];
        end
        for (int c = 0; c < 3; c++) begin
            b_in[0][c] = int'(m_top[c*16 +: 16]);
            for (int r = 1; r < 3; r++) b_in[r][c] = br[r-1][c];
        end
        if (m_stat) begin
            acc_n = '{default: 0}; ar_n = '{default: 0}; br_n = '{default: 0}; shm_n = 1'b0;
        end else if (shm) begin
            for (int c = 0; c < 3; c++) begin
                acc_n[0][c] = 0;
                for (int r = 1; r < 3; r++) acc_n[r][c] = acc[r-1][c];
            end
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    acc_n[r][c] = acc[r][c] + a_in[r][c] * b_in[r][c];
                    ar_n[r][c]  = a_in[r][c];
                    br_n[r][c]  = b_in[r][c];
                end
        end
        if (m_osel) shm_n = 1'b1;
    end

    always @(posedge clk) begin
        if (rst) begin
            acc <= '{default: 0}; ar <= '{default: 0}; br <= '{default: 0}; shm <= 1'b0;
        end else begin
            acc <= acc_n; ar <= ar_n; br <= br_n; shm <= shm_n;
        end
    end

    always_comb begin
        bot48 = '0;
        for (int c = 0; c < 3; c++)
            if (c < C) bot48[c*16 +: 16] = 16'(acc[R-1][c]);
    end

    assign if0.bottom_out = bot48[31:0];
    assign if1.bottom_out = bot48;
    assign if2.bottom_out = bot48;
    assign if3.bottom_out = bot48[31:0];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int tag, input logic [47:0] data, input logic [2:0] ocv);
        exp_t e;
        e.tag = tag; e.data = data; e.ocv = ocv;
        sb.push_back(e);
    endtask

    // Monitor: every valid output row is matched against the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && m_ocv != 3'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_row", 64'(m_ocv), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("row_tag", 64'(m_row), 64'(e.tag));
                    chk("row_data", 64'(m_out), 64'(e.data));
                    chk("col_valid", 64'(m_ocv), 64'(e.ocv));
                end
            end
        end
    end

    task automatic go(input int lat, input int rows, input bit skew);
        int n;
        bit seen;
        @(negedge clk); start_v = 1'b1;
        @(posedge clk); #1; start_v = 1'b0;
        chk("clear_pulse", 64'(m_stat), 64'd1);
        n = 0; seen = 1'b0;
        while (!seen && n < lat + 8) begin
            @(posedge clk); #1; n++;
            if (n == lat - rows - 2) chk("shift_sel_pulse", 64'(m_osel), 64'd1);
            if (skew && n == 4) begin
                chk("skew_left_t2", 64'(m_left), 64'({16'd20, 16'd11, 16'd2}));
                chk("skew_top_t2", 64'(m_top), 64'({16'd0, 16'd1, 16'd0}));
            end
            if (skew && n == 7) chk("skew_left_t5", 64'(m_left), 64'd0);
            seen = m_done;
        end
        chk("done_latency", 64'(n + 1), 64'(lat));
        @(posedge clk); #1;
        chk("idle_after_done", 64'(m_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, dn, rises, t2;
        bit prev_busy;
        if0.left_matrix = '0; if0.top_matrix = '0;
        if1.left_matrix = '0; if1.top_matrix = '0;
        if2.left_matrix = '0; if2.top_matrix = '0;
        if3.left_matrix = '0; if3.top_matrix = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(m_busy), 64'd0);
        chk("rst_ctrl", 64'({m_stat, m_osel, m_done, m_setst, m_ocv}), 64'd0);
        chk("rst_buses", 64'({m_left, m_top}), 64'd0);
        rst = 1'b0;

        // 2x2x2 baseline
        sel = 0;
        if0.left_matrix = {16'd4, 16'd3, 16'd2, 16'd1};
        if0.top_matrix  = {16'd8, 16'd7, 16'd6, 16'd5};
        push(1, {16'd0, 16'd50, 16'd43}, 3'b011);
        push(0, {16'd0, 16'd22, 16'd19}, 3'b011);
        go(11, 2, 1'b0);

        // Abort mid-FEED at t=1
        @(negedge clk); start_v = 1'b1;
        @(posedge clk); #1; start_v = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("busy_mid_feed", 64'(m_busy), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(m_busy), 64'd0);
        chk("abort_buses", 64'({m_left, m_top}), 64'd0);
        chk("abort_ctrl", 64'({m_stat, m_osel, m_done, m_ocv}), 64'd0);
        chk("abort_row", 64'(m_row), 64'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("no_restart_after_abort", 64'(m_busy), 64'd0);

        push(1, {16'd0, 16'd50, 16'd43}, 3'b011);
        push(0, {16'd0, 16'd22, 16'd19}, 3'b011);
        go(11, 2, 1'b0);

        // start held high: exactly two runs back to back, one done each
        repeat (2) push(1, {16'd0, 16'd50, 16'd43}, 3'b011);
        sb.insert(1, sb[sb.size()-1]);
        sb[1].tag = 0; sb[1].data = {16'd0, 16'd22, 16'd19};
        push(0, {16'd0, 16'd22, 16'd19}, 3'b011);
        @(negedge clk); start_v = 1'b1;
        n = 0; dn = 0; rises = 0; t2 = 0; prev_busy = m_busy;
        while (dn < 2 && n < 60) begin
            @(posedge clk); #1; n++;
            if (m_busy && !prev_busy) rises++;
            prev_busy = m_busy;
            if (m_done) begin
                dn++;
                if (dn == 2) t2 = n;
            end
        end
        start_v = 1'b0;
        chk("held_done_count", 64'(dn), 64'd2);
        chk("held_start_count", 64'(rises), 64'd2);
        chk("held_second_done_cycle", 64'(t2), 64'd23);
        repeat (4) @(posedge clk);
        #1 chk("held_no_third_run", 64'(m_busy), 64'd0);

        // Non-square 2x3, K=4
        sel = 1;
        if1.left_matrix = {8{16'd1}};
        if1.top_matrix  = {4{16'd3, 16'd2, 16'd1}};
        push(1, {16'd12, 16'd8, 16'd4}, 3'b111);
        push(0, {16'd12, 16'd8, 16'd4}, 3'b111);
        go(15, 2, 1'b0);

        // 3x3x3 skew check, B = identity so C = A
        sel = 2;
        if2.left_matrix = {16'd22, 16'd21, 16'd20, 16'd12, 16'd11, 16'd10, 16'd2, 16'd1, 16'd0};
        if2.top_matrix  = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
        push(2, {16'd22, 16'd21, 16'd20}, 3'b111);
        push(1, {16'd12, 16'd11, 16'd10}, 3'b111);
        push(0, {16'd2, 16'd1, 16'd0}, 3'b111);
        go(16, 3, 1'b1);

        // K_DIM=1
        sel = 3;
        if3.left_matrix = {16'd3, 16'd2};
        if3.top_matrix  = {16'd5, 16'd4};
        push(1, {16'd0, 16'd15, 16'd12}, 3'b011);
        push(0, {16'd0, 16'd10, 16'd8}, 3'b011);
        go(10, 2, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
